// File: rtl/ro_scan_ctrl.sv
// Ring-oscillator scan sequencer. Enables one unmasked RO at a time, counts its
// synchronized rising edges over a gate window, and streams out (index, count).
module ro_scan_ctrl #(
    parameter int NUM_RO        = 8,
    parameter int CNT_WIDTH     = 16,
    parameter int WIN_WIDTH     = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iStart,
    input  logic [NUM_RO-1:0]          iMask,
    input  logic [WIN_WIDTH-1:0]       iWindow,
    input  logic [NUM_RO-1:0]          iOsc,
    output logic [NUM_RO-1:0]          oEn,
    output logic                       oValid,
    input  logic                       iReady,
    output logic [$clog2(NUM_RO)-1:0]  oIdx,
    output logic [CNT_WIDTH-1:0]       oCount,
    output logic                       oBusy,
    output logic                       oDone
);

    localparam int IDX_W = $clog2(NUM_RO);
    localparam logic [WIN_WIDTH-1:0] SETTLE_LOAD = WIN_WIDTH'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} stateT;

    stateT                           state;
    logic [SYNC_STAGES-1:0][NUM_RO-1:0] syncFf;
    logic                            prevSample;
    logic                            selSync;
    logic                            oscEdge;
    logic [NUM_RO-1:0]               maskReg;
    logic [WIN_WIDTH-1:0]            winReg;
    logic [WIN_WIDTH-1:0]            timer;
    logic [CNT_WIDTH-1:0]            cnt;
    logic [CNT_WIDTH-1:0]            cntNext;
    logic [IDX_W-1:0]                firstIdx;
    logic [IDX_W-1:0]                nextIdx;
    logic                            nextFound;

    function automatic logic [NUM_RO-1:0] oneHot(input logic [IDX_W-1:0] idx);
        return NUM_RO'(1) << idx;
    endfunction

    // Every RO input is synchronized; only the selected channel feeds the edge detector.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            syncFf     <= '0;
            prevSample <= 1'b0;
        end else begin
            syncFf[0] <= iOsc;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                syncFf[s] <= syncFf[s-1];
            end
            prevSample <= selSync;
        end
    end

    assign selSync = syncFf[SYNC_STAGES-1][oIdx];
    assign oscEdge = selSync & ~prevSample;
    assign cntNext = (oscEdge && (cnt != '1)) ? cnt + CNT_WIDTH'(1) : cnt;

    // NOTE: every output of this block gets a default before the loop, so no latch is inferred.
    always_comb begin
        firstIdx  = '0;
        nextIdx   = '0;
        nextFound = 1'b0;
        // Descending walk: the last hit is the lowest qualifying index.
        for (int i = NUM_RO - 1; i >= 0; i--) begin
            if (iMask[i]) begin
                firstIdx = IDX_W'(i);
            end
            if (maskReg[i] && (i > int'(oIdx))) begin
                nextFound = 1'b1;
                nextIdx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            oEn     <= '0;
            oValid  <= 1'b0;
            oIdx    <= '0;
            oCount  <= '0;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            maskReg <= '0;
            winReg  <= '0;
            timer   <= '0;
            cnt     <= '0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        if (iMask != '0) begin
                            maskReg <= iMask;
                            winReg  <= (iWindow == '0) ? WIN_WIDTH'(1) : iWindow;
                            oIdx    <= firstIdx;
                            oEn     <= oneHot(firstIdx);
                            oBusy   <= 1'b1;
                            timer   <= SETTLE_LOAD;
                            state   <= SETTLE;
                        end else begin
                            oDone <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    cnt <= '0;
                    if (timer == '0) begin
                        timer <= winReg - WIN_WIDTH'(1);
                        state <= MEASURE;
                    end else begin
                        timer <= timer - WIN_WIDTH'(1);
                    end
                end
                MEASURE: begin
                    cnt <= cntNext;
                    if (timer == '0) begin
                        // The RO is switched off on the same edge the result appears.
                        oEn    <= '0;
                        oValid <= 1'b1;
                        oCount <= cntNext;
                        state  <= REPORT;
                    end else begin
                        timer <= timer - WIN_WIDTH'(1);
                    end
                end
                REPORT: begin
                    if (iReady) begin
                        oValid <= 1'b0;
                        if (nextFound) begin
                            oIdx  <= nextIdx;
                            oEn   <= oneHot(nextIdx);
                            timer <= SETTLE_LOAD;
                            state <= SETTLE;
                        end else begin
                            oBusy <= 1'b0;
                            oDone <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// Directed bench for ro_scan_ctrl: a default instance and a 4-bit-counter instance
// share all inputs so saturation is observed on the same stimulus.
module tb_ro_scan_ctrl;

    localparam int NUM_RO = 8;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic        iReady;
    logic [7:0]  iMask;
    logic [15:0] iWindow;
    logic [7:0]  iOsc;

    logic [7:0]  oEn,    satEn;
    logic        oValid, satValid;
    logic [2:0]  oIdx,   satIdx;
    logic [15:0] oCount;
    logic [3:0]  satCount;
    logic        oBusy,  satBusy;
    logic        oDone,  satDone;

    int halfPer [NUM_RO] = '{default: 0};
    int phase   [NUM_RO] = '{default: 0};
    int checks = 0;
    int errors = 0;

    ro_scan_ctrl dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iMask(iMask), .iWindow(iWindow),
        .iOsc(iOsc), .oEn(oEn), .oValid(oValid), .iReady(iReady), .oIdx(oIdx),
        .oCount(oCount), .oBusy(oBusy), .oDone(oDone)
    );

    ro_scan_ctrl #(.CNT_WIDTH(4)) dutSat (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iMask(iMask), .iWindow(iWindow),
        .iOsc(iOsc), .oEn(satEn), .oValid(satValid), .iReady(iReady), .oIdx(satIdx),
        .oCount(satCount), .oBusy(satBusy), .oDone(satDone)
    );

    always #5 iClk = ~iClk;

    // Oscillator models: bit i toggles every halfPer[i] cycles, held low when 0.
    initial begin
        iOsc = '0;
        forever begin
            @(negedge iClk);
            for (int i = 0; i < NUM_RO; i++) begin
                if (halfPer[i] == 0) begin
                    iOsc[i]  = 1'b0;
                    phase[i] = 0;
                end else begin
                    phase[i]++;
                    if (phase[i] >= halfPer[i]) begin
                        phase[i] = 0;
                        iOsc[i]  = ~iOsc[i];
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic startScan(input logic [7:0] mask, input logic [15:0] win);
        iMask   = mask;
        iWindow = win;
        iStart  = 1'b1;
        tick();
        iStart  = 1'b0;
    endtask

    // Counts sampled cycles with any enable high; stops on the first REPORT cycle.
    task automatic countEn(output int n);
        n = 0;
        while (oEn != '0 && n < 5000) begin
            n++;
            tick();
        end
    endtask

    int          n;
    int          unstable;
    int          badEn;
    int          enCyc;
    int          validCyc;
    int          loops;
    int          resIdx[$];
    logic [2:0]  holdIdx;
    logic [15:0] holdCnt;

    initial begin
        iRst = 1'b1; iStart = 1'b0; iReady = 1'b0; iMask = '0; iWindow = '0;
        repeat (3) tick();
        check("rst_en",    oEn,    0);
        check("rst_valid", oValid, 0);
        check("rst_busy",  oBusy,  0);
        check("rst_done",  oDone,  0);
        check("rst_count", oCount, 0);
        check("rst_idx",   oIdx,   0);
        iRst = 1'b0;
        tick();

        // Single RO, period 16 over a 100-cycle gate, with backpressure and an ignored start.
        halfPer[2] = 8;
        startScan(8'h04, 16'd100);
        check("single_en_onehot", oEn, 8'h04);
        check("single_busy", oBusy, 1);
        countEn(n);
        check("single_en_cycles", n, 104);
        check("single_valid", oValid, 1);
        check("single_idx", oIdx, 2);
        check("single_count_6_or_7", (oCount == 16'd6) || (oCount == 16'd7), 1);
        holdIdx  = oIdx;
        holdCnt  = oCount;
        unstable = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                iMask = 8'hFF; iWindow = 16'd5; iStart = 1'b1;
            end else begin
                iStart = 1'b0;
            end
            if (oValid !== 1'b1 || oIdx !== holdIdx || oCount !== holdCnt || oEn !== '0 || oBusy !== 1'b1)
                unstable++;
            tick();
        end
        iStart = 1'b0;
        check("bp_unstable_cycles", unstable, 0);
        iReady = 1'b1;
        tick();
        check("single_done", oDone, 1);
        check("single_busy_low", oBusy, 0);
        check("single_valid_low", oValid, 0);
        iReady = 1'b0;
        tick();
        check("single_done_pulse", oDone, 0);
        check("busy_start_ignored", oBusy, 0);

        // Scan order and mask with iReady held high.
        halfPer[2] = 0;
        iReady = 1'b1;
        startScan(8'hA1, 16'd8);
        badEn = 0; enCyc = 0; validCyc = 0; loops = 0;
        resIdx.delete();
        while (oBusy && loops < 1000) begin
            if ((oEn & ~8'hA1) != '0 || $countones(oEn) > 1) badEn++;
            if (oEn != '0) enCyc++;
            if (oValid) begin
                validCyc++;
                resIdx.push_back(int'(oIdx));
            end
            if (oDone) badEn++;
            loops++;
            tick();
        end
        check("scan_results", resIdx.size(), 3);
        check("scan_idx0", (resIdx.size() > 0) ? resIdx[0] : -1, 0);
        check("scan_idx1", (resIdx.size() > 1) ? resIdx[1] : -1, 5);
        check("scan_idx2", (resIdx.size() > 2) ? resIdx[2] : -1, 7);
        check("scan_bad_en", badEn, 0);
        check("scan_en_cycles", enCyc, 36);
        check("scan_valid_cycles", validCyc, 3);
        check("scan_done", oDone, 1);
        tick();
        check("scan_done_pulse", oDone, 0);

        // Backpressure between two ROs; next SETTLE starts right after the transfer.
        iReady = 1'b0;
        startScan(8'h06, 16'd0);
        check("bp_first_en", oEn, 8'h02);
        countEn(n);
        check("bp_first_en_cycles", n, 5);
        check("bp_first_idx", oIdx, 1);
        unstable = 0;
        for (int c = 0; c < 20; c++) begin
            if (oValid !== 1'b1 || oIdx !== 3'd1 || oEn !== '0) unstable++;
            tick();
        end
        check("bp_hold", unstable, 0);
        iReady = 1'b1;
        tick();
        check("bp_next_en", oEn, 8'h04);
        check("bp_next_idx", oIdx, 2);
        check("bp_next_valid_low", oValid, 0);
        countEn(n);
        check("bp_second_en_cycles", n, 5);
        check("bp_second_valid", oValid, 1);
        tick();
        check("bp_done", oDone, 1);

        // Empty mask: immediate done pulse, nothing enabled.
        iReady = 1'b0;
        startScan(8'h00, 16'd10);
        check("empty_done", oDone, 1);
        check("empty_en", oEn, 0);
        check("empty_busy", oBusy, 0);
        tick();
        check("empty_done_pulse", oDone, 0);

        // Period-4 input over 64 cycles: 16 edges, saturating at 15 on the 4-bit counter.
        halfPer[0] = 2;
        startScan(8'h01, 16'd64);
        countEn(n);
        check("sat_en_cycles", n, 68);
        check("full_count", oCount, 16);
        check("sat_count", satCount, 15);
        check("sat_valid", satValid, 1);
        check("sat_idx", satIdx, 0);
        check("sat_en_off", satEn, 0);
        iReady = 1'b1;
        tick();
        check("sat_done", satDone, 1);
        check("sat_busy_low", satBusy, 0);
        tick();

        // Reset held 3 cycles mid-MEASURE drops everything.
        iReady = 1'b0;
        startScan(8'h01, 16'd50);
        repeat (10) tick();
        check("mid_busy", oBusy, 1);
        iRst = 1'b1;
        tick();
        check("mid_rst_en", oEn, 0);
        check("mid_rst_valid", oValid, 0);
        check("mid_rst_busy", oBusy, 0);
        check("mid_rst_count", oCount, 0);
        check("mid_rst_sat_count", satCount, 0);
        repeat (2) tick();
        iRst = 1'b0;
        tick();
        check("post_rst_idle", oBusy, 0);

        // Window 0 behaves as a one-cycle gate.
        iReady = 1'b1;
        startScan(8'h01, 16'd0);
        countEn(n);
        check("win0_en_cycles", n, 5);
        check("win0_valid", oValid, 1);
        tick();
        check("win0_done", oDone, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
